// File: rtl/dma_pkg.sv
// Shared DMA definitions: AXI size/response encodings, burst limit and read FSM states.
package dma_pkg;

  localparam int FIXED_BURST_SIZE = 256;

  localparam logic [2:0] SIZE_1B = 3'b000;
  localparam logic [2:0] SIZE_2B = 3'b001;
  localparam logic [2:0] SIZE_4B = 3'b010;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_PRE,
    RD_START,
    RD_SEQ
  } rd_state_t;

  // Words in the next burst: the remainder, capped at the fixed burst size.
  function automatic logic [8:0] burst_len(input logic [31:0] remaining);
    return (remaining >= 32'(FIXED_BURST_SIZE)) ? 9'(FIXED_BURST_SIZE) : remaining[8:0];
  endfunction

endpackage

// File: rtl/dma_read.sv
// AXI4 read master streaming num_trans 32-bit words from start_addr, one burst in flight.
// Define DMA_READ_RLAST_CHECK_EN to also flag beats whose RLAST disagrees with the beat count.
module dma_read
  import dma_pkg::*;
#(
  parameter int BITS_TRANS       = 18,
  parameter int AXI_WIDTH_ID     = 4,
  parameter int AXI_WIDTH_AD     = 32,
  parameter int AXI_WIDTH_DA     = 32,
  parameter int AXI_WIDTH_ARUSER = 1,
  parameter int AXI_WIDTH_RUSER  = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic [AXI_WIDTH_ID-1:0]     M_AXI_ARID,
  output logic [AXI_WIDTH_AD-1:0]     M_AXI_ARADDR,
  output logic [7:0]                  M_AXI_ARLEN,
  output logic [2:0]                  M_AXI_ARSIZE,
  output logic [1:0]                  M_AXI_ARBURST,
  output logic                        M_AXI_ARLOCK,
  output logic [3:0]                  M_AXI_ARCACHE,
  output logic [2:0]                  M_AXI_ARPROT,
  output logic [3:0]                  M_AXI_ARQOS,
  output logic [AXI_WIDTH_ARUSER-1:0] M_AXI_ARUSER,
  output logic                        M_AXI_ARVALID,
  input  logic                        M_AXI_ARREADY,
  input  logic [AXI_WIDTH_ID-1:0]     M_AXI_RID,
  input  logic [AXI_WIDTH_DA-1:0]     M_AXI_RDATA,
  input  logic [1:0]                  M_AXI_RRESP,
  input  logic                        M_AXI_RLAST,
  input  logic [AXI_WIDTH_RUSER-1:0]  M_AXI_RUSER,
  input  logic                        M_AXI_RVALID,
  output logic                        M_AXI_RREADY,
  input  logic                        start_dma,
  input  logic [BITS_TRANS-1:0]       num_trans,
  input  logic [AXI_WIDTH_AD-1:0]     start_addr,
  output logic                        done_o,
  output logic [AXI_WIDTH_DA-1:0]     outdata_o,
  output logic                        outdata_vld_o,
  input  logic                        outdata_rdy_i,
  output logic                        fail_check
);

  rd_state_t             state_q;
  logic [BITS_TRANS-1:0] num_trans_q, words_done_q;
  logic [AXI_WIDTH_AD-1:0] addr_q;
  logic [7:0]            arlen_q, beat_q;
  logic                  arvalid_q, done_q, fail_q;
  logic [8:0]            blen_d, burst_words;
  logic                  in_seq, beat_acc, beat_err, unused_rd;

  assign blen_d      = burst_len(32'(num_trans_q - words_done_q));
  assign burst_words = {1'b0, arlen_q} + 9'd1;
  assign in_seq      = (state_q == RD_SEQ);
  assign beat_acc    = in_seq && M_AXI_RVALID && outdata_rdy_i;

`ifdef DMA_READ_RLAST_CHECK_EN
  assign beat_err  = (M_AXI_RRESP != RESP_OKAY) || (M_AXI_RLAST != (beat_q == arlen_q));
  assign unused_rd = ^{M_AXI_RID, M_AXI_RUSER};
`else
  assign beat_err  = (M_AXI_RRESP != RESP_OKAY);
  assign unused_rd = ^{M_AXI_RID, M_AXI_RUSER, M_AXI_RLAST};
`endif

  assign M_AXI_ARID    = '0;
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_ARLOCK  = 1'b0;
  assign M_AXI_ARCACHE = 4'b0011;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARQOS   = 4'b1111;
  assign M_AXI_ARUSER  = '0;
  assign M_AXI_ARSIZE  = SIZE_4B;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARLEN   = arlen_q;
  assign M_AXI_ARVALID = arvalid_q;

  // The R channel is a straight pass-through to the consumer while a burst is open.
  assign M_AXI_RREADY  = in_seq && outdata_rdy_i;
  assign outdata_vld_o = in_seq && M_AXI_RVALID;
  assign outdata_o     = in_seq ? M_AXI_RDATA : '0;
  assign done_o        = done_q;
  assign fail_check    = fail_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RD_IDLE;
      num_trans_q  <= '0;
      words_done_q <= '0;
      addr_q       <= '0;
      arlen_q      <= '0;
      beat_q       <= '0;
      arvalid_q    <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      fail_q <= 1'b0;
      case (state_q)
        RD_IDLE: begin
          if (start_dma) begin
            num_trans_q  <= num_trans;
            addr_q       <= start_addr;
            words_done_q <= '0;
            beat_q       <= '0;
            state_q      <= RD_PRE;
          end
        end
        RD_PRE: begin
          if (words_done_q == num_trans_q) begin
            done_q  <= 1'b1;
            state_q <= RD_IDLE;
          end else begin
            arlen_q   <= 8'(blen_d - 9'd1);
            arvalid_q <= 1'b1;
            state_q   <= RD_START;
          end
        end
        RD_START: begin
          if (M_AXI_ARREADY) begin
            arvalid_q <= 1'b0;
            beat_q    <= '0;
            state_q   <= RD_SEQ;
          end
        end
        RD_SEQ: begin
          if (beat_acc) begin
            fail_q <= beat_err;
            beat_q <= beat_q + 8'd1;
            // Completion is decided by the beat count alone, never by RLAST.
            if (beat_q == arlen_q) begin
              words_done_q <= words_done_q + BITS_TRANS'(burst_words);
              addr_q       <= addr_q + AXI_WIDTH_AD'({burst_words, 2'b00});
              state_q      <= RD_PRE;
            end
          end
        end
        default: state_q <= RD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_read.sv
// Directed bench for dma_read with an in-line AXI read slave and stream consumer.
module tb_dma_read;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize, arprot;
  logic [1:0]  arburst;
  logic        arlock;
  logic [3:0]  arcache, arqos;
  logic [0:0]  aruser;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic [0:0]  ruser;
  logic        rvalid, rready;
  logic        start_dma;
  logic [17:0] num_trans;
  logic [31:0] start_addr;
  logic        done_o;
  logic [31:0] outdata_o;
  logic        outdata_vld_o, outdata_rdy_i, fail_check;

  dma_read dut (
    .clk(clk), .rst(rst),
    .M_AXI_ARID(arid), .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize),
    .M_AXI_ARBURST(arburst), .M_AXI_ARLOCK(arlock), .M_AXI_ARCACHE(arcache),
    .M_AXI_ARPROT(arprot), .M_AXI_ARQOS(arqos), .M_AXI_ARUSER(aruser),
    .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RID(rid), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RLAST(rlast),
    .M_AXI_RUSER(ruser), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready),
    .start_dma(start_dma), .num_trans(num_trans), .start_addr(start_addr),
    .done_o(done_o), .outdata_o(outdata_o), .outdata_vld_o(outdata_vld_o),
    .outdata_rdy_i(outdata_rdy_i), .fail_check(fail_check)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [31:0] ar_addr_log[$];
  logic [7:0]  ar_len_log[$];
  logic [31:0] words[$];
  int          done_cnt, fail_cnt, done_cycle, proto_err;
  bit          arvalid_seen, timed_out;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic idle_inputs();
    start_dma = 1'b0; arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
    rlast = 1'b0; outdata_rdy_i = 1'b0; rid = '0; ruser = '0;
  endtask

  // Runs one transfer, acting as slave and consumer; records what the DUT did.
  task automatic run_xfer(input int n, input logic [31:0] addr, input int ar_delay,
                          input bit rand_rdy, input int err_beat, input int max_cycles,
                          input bit stop_at_max);
    bit          ar_pend, r_active;
    int          ar_wait, r_beat, gbeat, post;
    logic [31:0] hold_addr, r_addr;
    logic [7:0]  hold_len, r_len;
    ar_addr_log.delete(); ar_len_log.delete(); words.delete();
    done_cnt = 0; fail_cnt = 0; done_cycle = -1; proto_err = 0;
    arvalid_seen = 0; timed_out = 0;
    ar_pend = 0; r_active = 0; ar_wait = 0; r_beat = 0; gbeat = 0; post = 0;
    hold_addr = '0; hold_len = '0; r_addr = '0; r_len = '0;
    num_trans = 18'(n); start_addr = addr;
    for (int cyc = 0; cyc < max_cycles; cyc++) begin
      @(negedge clk);
      if (done_o) begin done_cnt++; if (done_cycle < 0) done_cycle = cyc; end
      if (fail_check) fail_cnt++;
      if (done_cnt > 0 && !stop_at_max) begin post++; if (post > 3) break; end
      start_dma = (cyc == 0);
      if (r_active) begin
        rvalid = 1'b1;
        rdata  = data_of(r_addr + 32'(4 * r_beat));
        rlast  = (r_beat == int'(r_len));
        rresp  = (gbeat == err_beat) ? 2'b10 : 2'b00;
      end else begin
        rvalid = 1'b0; rdata = '0; rlast = 1'b0; rresp = 2'b00;
      end
      arready = 1'b0;
      if (arvalid) begin
        arvalid_seen = 1;
        if (r_active) proto_err++;
        if (!ar_pend) begin
          ar_pend = 1; ar_wait = 0; hold_addr = araddr; hold_len = arlen;
        end else if (araddr !== hold_addr || arlen !== hold_len) begin
          proto_err++;
        end
        if (ar_wait >= ar_delay) begin
          arready = 1'b1; ar_pend = 0;
          ar_addr_log.push_back(araddr); ar_len_log.push_back(arlen);
          r_active = 1; r_beat = 0; r_len = arlen; r_addr = araddr;
        end else begin
          ar_wait++;
        end
      end else if (ar_pend) begin
        proto_err++;
      end
      outdata_rdy_i = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      if (outdata_vld_o && outdata_rdy_i) words.push_back(outdata_o);
      if (rvalid && rready) begin
        r_beat++; gbeat++;
        if (r_beat > int'(r_len)) r_active = 0;
      end
    end
    if (!stop_at_max && done_cnt == 0) timed_out = 1;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset();
    rst = 1'b1; start_dma = 1'b1; outdata_rdy_i = 1'b1; num_trans = 18'd5; start_addr = 32'h40;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (arvalid !== 1'b0) begin failures++; $display("FAIL reset_arvalid got=%b want=0", arvalid); end
    checks++; if (rready !== 1'b0) begin failures++; $display("FAIL reset_rready got=%b want=0", rready); end
    checks++; if (outdata_vld_o !== 1'b0) begin failures++; $display("FAIL reset_outvld got=%b want=0", outdata_vld_o); end
    checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done_o); end
    checks++; if (fail_check !== 1'b0) begin failures++; $display("FAIL reset_fail got=%b want=0", fail_check); end
    checks++; if (araddr !== 32'h0) begin failures++; $display("FAIL reset_araddr got=%h want=0", araddr); end
    checks++; if (arlen !== 8'h0) begin failures++; $display("FAIL reset_arlen got=%h want=0", arlen); end
    checks++; if (arsize !== 3'b010) begin failures++; $display("FAIL const_arsize got=%b want=010", arsize); end
    checks++; if (arburst !== 2'b01) begin failures++; $display("FAIL const_arburst got=%b want=01", arburst); end
    checks++; if (arcache !== 4'b0011) begin failures++; $display("FAIL const_arcache got=%b want=0011", arcache); end
    checks++; if (arqos !== 4'b1111) begin failures++; $display("FAIL const_arqos got=%b want=1111", arqos); end
    checks++; if ({arid, arlock, arprot, aruser} !== 9'b0) begin failures++; $display("FAIL const_misc got=%b want=0", {arid, arlock, arprot, aruser}); end
    idle_inputs();
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_burst();
    run_xfer(16, 32'h1000, 0, 0, -1, 200, 0);
    checks++; if (timed_out !== 1'b0) begin failures++; $display("FAIL single_timeout got=%b want=0", timed_out); end
    checks++; if (ar_addr_log.size() !== 1) begin failures++; $display("FAIL single_ar_count got=%0d want=1", ar_addr_log.size()); end
    if (ar_addr_log.size() > 0) begin
      checks++; if (ar_addr_log[0] !== 32'h1000) begin failures++; $display("FAIL single_araddr got=%h want=1000", ar_addr_log[0]); end
      checks++; if (ar_len_log[0] !== 8'd15) begin failures++; $display("FAIL single_arlen got=%0d want=15", ar_len_log[0]); end
    end
    checks++; if (words.size() !== 16) begin failures++; $display("FAIL single_words got=%0d want=16", words.size()); end
    for (int i = 0; i < words.size() && i < 16; i++) begin
      checks++; if (words[i] !== data_of(32'h1000 + 32'(4 * i))) begin failures++; $display("FAIL single_word%0d got=%h want=%h", i, words[i], data_of(32'h1000 + 32'(4 * i))); end
    end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL single_done got=%0d want=1", done_cnt); end
    checks++; if (fail_cnt !== 0) begin failures++; $display("FAIL single_failcheck got=%0d want=0", fail_cnt); end
    checks++; if (proto_err !== 0) begin failures++; $display("FAIL single_proto got=%0d want=0", proto_err); end
  endtask

  task automatic test_multi_burst();
    logic [31:0] exp_addr [3];
    logic [7:0]  exp_len  [3];
    exp_addr = '{32'h0, 32'h400, 32'h800};
    exp_len  = '{8'd255, 8'd255, 8'd87};
    run_xfer(600, 32'h0, 0, 0, -1, 2000, 0);
    checks++; if (timed_out !== 1'b0) begin failures++; $display("FAIL multi_timeout got=%b want=0", timed_out); end
    checks++; if (ar_addr_log.size() !== 3) begin failures++; $display("FAIL multi_ar_count got=%0d want=3", ar_addr_log.size()); end
    for (int i = 0; i < ar_addr_log.size() && i < 3; i++) begin
      checks++; if (ar_addr_log[i] !== exp_addr[i]) begin failures++; $display("FAIL multi_araddr%0d got=%h want=%h", i, ar_addr_log[i], exp_addr[i]); end
      checks++; if (ar_len_log[i] !== exp_len[i]) begin failures++; $display("FAIL multi_arlen%0d got=%0d want=%0d", i, ar_len_log[i], exp_len[i]); end
    end
    checks++; if (words.size() !== 600) begin failures++; $display("FAIL multi_words got=%0d want=600", words.size()); end
    for (int i = 0; i < words.size() && i < 600; i++) begin
      checks++; if (words[i] !== data_of(32'(4 * i))) begin failures++; $display("FAIL multi_word%0d got=%h want=%h", i, words[i], data_of(32'(4 * i))); end
    end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL multi_done got=%0d want=1", done_cnt); end
    checks++; if (proto_err !== 0) begin failures++; $display("FAIL multi_proto got=%0d want=0", proto_err); end
  endtask

  task automatic test_backpressure();
    run_xfer(40, 32'h2000, 5, 1, -1, 1000, 0);
    checks++; if (timed_out !== 1'b0) begin failures++; $display("FAIL bp_timeout got=%b want=0", timed_out); end
    checks++; if (ar_addr_log.size() !== 1) begin failures++; $display("FAIL bp_ar_count got=%0d want=1", ar_addr_log.size()); end
    checks++; if (proto_err !== 0) begin failures++; $display("FAIL bp_arvalid_hold got=%0d want=0", proto_err); end
    checks++; if (words.size() !== 40) begin failures++; $display("FAIL bp_words got=%0d want=40", words.size()); end
    for (int i = 0; i < words.size() && i < 40; i++) begin
      checks++; if (words[i] !== data_of(32'h2000 + 32'(4 * i))) begin failures++; $display("FAIL bp_word%0d got=%h want=%h", i, words[i], data_of(32'h2000 + 32'(4 * i))); end
    end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL bp_done got=%0d want=1", done_cnt); end
  endtask

  task automatic test_error_beat();
    run_xfer(8, 32'h0100, 0, 0, 3, 200, 0);
    checks++; if (fail_cnt !== 1) begin failures++; $display("FAIL err_failcheck got=%0d want=1", fail_cnt); end
    checks++; if (words.size() !== 8) begin failures++; $display("FAIL err_words got=%0d want=8", words.size()); end
    for (int i = 0; i < words.size() && i < 8; i++) begin
      checks++; if (words[i] !== data_of(32'h0100 + 32'(4 * i))) begin failures++; $display("FAIL err_word%0d got=%h want=%h", i, words[i], data_of(32'h0100 + 32'(4 * i))); end
    end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL err_done got=%0d want=1", done_cnt); end
    checks++; if (ar_addr_log.size() !== 1) begin failures++; $display("FAIL err_no_retry got=%0d want=1", ar_addr_log.size()); end
  endtask

  task automatic test_zero_len();
    run_xfer(0, 32'h0200, 0, 0, -1, 50, 0);
    checks++; if (done_cycle !== 2) begin failures++; $display("FAIL zero_done_cycle got=%0d want=2", done_cycle); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL zero_done_count got=%0d want=1", done_cnt); end
    checks++; if (arvalid_seen !== 1'b0) begin failures++; $display("FAIL zero_arvalid got=%b want=0", arvalid_seen); end
    checks++; if (words.size() !== 0) begin failures++; $display("FAIL zero_words got=%0d want=0", words.size()); end
  endtask

  task automatic test_reset_mid();
    run_xfer(64, 32'h3000, 0, 0, -1, 20, 1);
    checks++; if (done_cnt !== 0) begin failures++; $display("FAIL mid_early_done got=%0d want=0", done_cnt); end
    checks++; if (words.size() == 0) begin failures++; $display("FAIL mid_not_started got=%0d want=>0", words.size()); end
    rst = 1'b1; outdata_rdy_i = 1'b1;
    @(negedge clk);
    checks++; if (arvalid !== 1'b0) begin failures++; $display("FAIL mid_rst_arvalid got=%b want=0", arvalid); end
    checks++; if (rready !== 1'b0) begin failures++; $display("FAIL mid_rst_rready got=%b want=0", rready); end
    checks++; if (outdata_o !== 32'h0) begin failures++; $display("FAIL mid_rst_outdata got=%h want=0", outdata_o); end
    checks++; if (araddr !== 32'h0) begin failures++; $display("FAIL mid_rst_araddr got=%h want=0", araddr); end
    rst = 1'b0; outdata_rdy_i = 1'b0;
    @(negedge clk);
    run_xfer(4, 32'h5000, 0, 0, -1, 100, 0);
    checks++; if (ar_addr_log.size() !== 1) begin failures++; $display("FAIL mid_new_ar_count got=%0d want=1", ar_addr_log.size()); end
    if (ar_addr_log.size() > 0) begin
      checks++; if (ar_addr_log[0] !== 32'h5000) begin failures++; $display("FAIL mid_new_araddr got=%h want=5000", ar_addr_log[0]); end
      checks++; if (ar_len_log[0] !== 8'd3) begin failures++; $display("FAIL mid_new_arlen got=%0d want=3", ar_len_log[0]); end
    end
    checks++; if (words.size() !== 4) begin failures++; $display("FAIL mid_new_words got=%0d want=4", words.size()); end
    for (int i = 0; i < words.size() && i < 4; i++) begin
      checks++; if (words[i] !== data_of(32'h5000 + 32'(4 * i))) begin failures++; $display("FAIL mid_new_word%0d got=%h want=%h", i, words[i], data_of(32'h5000 + 32'(4 * i))); end
    end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL mid_new_done got=%0d want=1", done_cnt); end
  endtask

  initial begin
    idle_inputs();
    num_trans = '0; start_addr = '0; rst = 1'b1;
    test_reset();
    test_single_burst();
    test_multi_burst();
    test_backpressure();
    test_error_beat();
    test_zero_len();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dma_read.md
DMA_READ -- requirements
Module: dma_read

Interface
REQ-001 SHALL have parameter BITS_TRANS, default 18: width of num_trans, in 32-bit words.
REQ-002 SHALL have parameter AXI_WIDTH_ID, default 4: AXI ID width.
REQ-003 SHALL have parameter AXI_WIDTH_AD, default 32: address width.
REQ-004 SHALL have parameter AXI_WIDTH_DA, default 32: data width; only 32 is supported.
REQ-005 SHALL have parameter AXI_WIDTH_ARUSER, default 1, and AXI_WIDTH_RUSER, default 1: user signal widths.
REQ-006 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-008 SHALL have the AR channel outputs M_AXI_ARVALID 1, M_AXI_ARADDR AD, M_AXI_ARLEN 8 and M_AXI_ARSIZE 3, plus input M_AXI_ARREADY 1.
REQ-009 SHALL drive these AR outputs as constants: M_AXI_ARID=0, ARBURST=01 (INCR), ARLOCK=0, ARCACHE=0011, ARPROT=000, ARQOS=1111, ARUSER=0.
REQ-010 SHALL have the R channel inputs M_AXI_RVALID 1, M_AXI_RDATA DA, M_AXI_RRESP 2, M_AXI_RLAST 1, M_AXI_RID ID and M_AXI_RUSER RUSER, plus output M_AXI_RREADY 1.
REQ-011 SHALL have the command inputs start_dma 1, num_trans BITS_TRANS and start_addr AD (byte address, 4-byte aligned).
REQ-012 SHALL have output done_o, 1: one-cycle pulse when the transfer completes.
REQ-013 SHALL have outputs outdata_o DA and outdata_vld_o 1, plus input outdata_rdy_i 1: stream out to the consumer.
REQ-014 SHALL have output fail_check, 1: one-cycle debug pulse on an error beat.

Function
REQ-015 SHALL use the FSM RD_IDLE -> RD_PRE -> RD_START -> RD_SEQ -> RD_PRE.
REQ-016 SHALL, when start_dma is seen in RD_IDLE, latch num_trans and start_addr, clear the word and beat counters, and enter RD_PRE; start_dma in any other state SHALL be ignored.
REQ-017 SHALL, in RD_PRE, pulse done_o and return to RD_IDLE if words_done == num_trans_q; otherwise it SHALL go to RD_START. With num_trans=0, done_o SHALL occur 2 cycles after start_dma, with no AR issued.
REQ-018 SHALL set burst length L = min(256, num_trans_q - words_done), with ARLEN = L-1 and ARSIZE = 010.
REQ-019 SHALL, in RD_START, assert ARVALID with ARADDR/ARLEN stable until ARREADY is sampled high, then enter RD_SEQ; ARVALID SHALL NOT drop before the handshake.
REQ-020 SHALL, in RD_SEQ, drive RREADY = outdata_rdy_i, outdata_vld_o = RVALID and outdata_o = RDATA combinationally; outside RD_SEQ RREADY and outdata_vld_o SHALL be 0.
REQ-021 SHALL count a beat on RVALID && RREADY; on beat L-1, words_done += L, address += 4*L, and the FSM SHALL enter RD_PRE.
REQ-022 SHALL keep exactly one burst outstanding at a time.
REQ-023 SHALL, for a beat with RRESP != 00, still forward the data, pulse fail_check, and not retry.
REQ-024 SHALL hold done_o, fail_check and ARVALID at 0 in RD_IDLE.

Reset
REQ-025 SHALL, while rst is high at a clock edge, enter RD_IDLE, zero all counters and latched registers, and drive all non-constant outputs to 0.
REQ-026 SHALL abandon a transfer when reset arrives mid-transfer, with no completion; the interconnect SHALL be reset alongside.

Configuration
REQ-027 SHALL, with DMA_READ_RLAST_CHECK_EN defined, pulse fail_check on an accepted beat whose RLAST disagrees with (beat == L-1); the FSM SHALL still advance on the beat count only.
REQ-028 SHALL, without DMA_READ_RLAST_CHECK_EN, ignore RLAST entirely.

Structure
REQ-029 SHALL take SIZE_*, RESP_*, FIXED_BURST_SIZE=256 and the rd_state_t enum from the shared package dma_pkg, which dma_write also uses.
REQ-030 SHALL be a single module with no sub-module.

Verification
REQ-031 SHALL cover: num_trans=16, addr 0x1000, always-ready slave -> one AR with ARLEN=15, 16 beats in order, one done_o pulse.
REQ-032 SHALL cover: num_trans=600 -> ARs at 0x0/0x400/0x800 with ARLEN 255/255/87, and 600 words out.
REQ-033 SHALL cover: random outdata_rdy_i low, ARREADY delayed 5 cycles -> no lost or duplicated word, ARVALID held.
REQ-034 SHALL cover: RRESP=10 on beat 3 -> exactly one fail_check pulse, all words delivered, done_o asserted.
REQ-035 SHALL cover: num_trans=0 -> done_o 2 cycles after start_dma, with ARVALID never asserted.
REQ-036 SHALL cover: rst asserted mid-burst, then a new start_dma -> a clean new transfer from the new start_addr.
